// File: rtl/fifo_apb_dac_pkg.sv
// Shared definitions for the APB-to-DAC transmit FIFO: register map, bit
// positions and output state encoding.
package fifo_apb_dac_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_PERIOD = 4'hC;

  // Word index of each register, i.e. paddr[3:2]
  typedef enum logic [1:0] {
    R_DATA   = 2'd0,
    R_CTRL   = 2'd1,
    R_STATUS = 2'd2,
    R_PERIOD = 2'd3
  } reg_e;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_CLEAR   = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_OVF       = 16;
  localparam int unsigned ST_UDR       = 17;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } out_state_e;

  function automatic reg_e reg_decode(input logic [3:0] addr);
    return reg_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/fifo_apb_dac_if.sv
// APB3 slave bus plus DAC valid/ready stream of the transmit FIFO.
// master = CPU/DAC side driving the block, slave = the block itself.
interface fifo_apb_dac_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            paddr;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  dac_valid;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_ready;
  logic                  irq;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, dac_ready,
    input  prdata, pready, pslverr, dac_valid, dac_data, irq
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, dac_ready,
    output prdata, pready, pslverr, dac_valid, dac_data, irq
  );

endinterface

// File: rtl/fifo_apb_dac_fifo_sync_core.sv
// Single-clock FIFO storage with occupancy count and synchronous flush.
// A push into a full FIFO is accepted when a pop frees a slot on the same edge.
module fifo_sync_core #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH = 2**AW, so its MSB alone marks full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_apb_dac.sv
// APB3-written sample FIFO paced out to a DAC over valid/ready, with a
// programmable inter-sample period, sticky overflow/underrun flags and irq.
module fifo_apb_dac
  import fifo_apb_dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  fifo_apb_dac_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  reg_e                  sel;
  logic                  wr_access;
  logic                  wr_data;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  wr_period;
  logic                  clear;

  logic                  enable_q;
  logic                  irq_en_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                  ovf_q;
  logic                  udr_q;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  out_state_e            state;
  logic                  dac_valid_q;
  logic [DATA_WIDTH-1:0] dac_data_q;
  logic [PERIOD_WIDTH-1:0] timer_q;
  logic                  primed_q;

  logic                  slot_free;
  logic                  launch_due;
  logic                  pop;
  logic                  ovf_set;
  logic                  udr_set;
  logic [31:0]           prdata_c;
  logic                  unused_bits;

  assign sel       = reg_decode(bus.paddr);
  assign wr_access = bus.psel & bus.penable & bus.pwrite;
  assign wr_data   = wr_access & (sel == R_DATA);
  assign wr_ctrl   = wr_access & (sel == R_CTRL);
  assign wr_status = wr_access & (sel == R_STATUS);
  assign wr_period = wr_access & (sel == R_PERIOD);
  assign clear     = wr_ctrl & bus.pwdata[CTRL_CLEAR];

  // The output slot frees either when idle or when the DAC takes the held word
  assign slot_free  = (state == S_IDLE) | bus.dac_ready;
  assign launch_due = enable_q & (timer_q == '0);
  assign pop        = launch_due & ~fifo_empty & slot_free & ~clear;
  assign ovf_set    = wr_data & fifo_full & ~pop;
  assign udr_set    = launch_due & primed_q & fifo_empty & slot_free & ~clear;

  fifo_sync_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (wr_data),
    .wdata (bus.pwdata[DATA_WIDTH-1:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= bus.pwdata[CTRL_ENABLE];
        irq_en_q <= bus.pwdata[CTRL_IRQ_EN];
      end
      if (wr_period) begin
        period_q <= bus.pwdata[PERIOD_WIDTH-1:0];
      end
      // A new event wins over a simultaneous write-1-to-clear
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (wr_status && bus.pwdata[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (udr_set) begin
        udr_q <= 1'b1;
      end else if (wr_status && bus.pwdata[ST_UDR]) begin
        udr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
      timer_q     <= '0;
      primed_q    <= 1'b0;
    end else if (clear) begin
      state       <= S_IDLE;
      dac_valid_q <= 1'b0;
      timer_q     <= '0;
      primed_q    <= 1'b0;
    end else begin
      if (!enable_q) begin
        primed_q <= 1'b0;
      end else if (pop) begin
        primed_q <= 1'b1;
      end

      if (pop) begin
        timer_q <= period_q;
      end else if (timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            dac_data_q  <= fifo_rdata;
            dac_valid_q <= 1'b1;
            state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (bus.dac_ready) begin
            if (pop) begin
              dac_data_q <= fifo_rdata;
            end else begin
              dac_valid_q <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    prdata_c = '0;
    case (sel)
      R_CTRL: begin
        prdata_c[CTRL_ENABLE] = enable_q;
        prdata_c[CTRL_IRQ_EN] = irq_en_q;
      end
      R_STATUS: begin
        prdata_c[ST_EMPTY]            = fifo_empty;
        prdata_c[ST_FULL]             = fifo_full;
        prdata_c[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
        prdata_c[ST_OVF]              = ovf_q;
        prdata_c[ST_UDR]              = udr_q;
      end
      R_PERIOD: prdata_c[PERIOD_WIDTH-1:0] = period_q;
      default: ;
    endcase
  end

  assign bus.prdata    = prdata_c;
  assign bus.pready    = 1'b1;
  assign bus.pslverr   = 1'b0;
  assign bus.dac_valid = dac_valid_q;
  assign bus.dac_data  = dac_data_q;
  assign bus.irq       = (ovf_q | udr_q) & irq_en_q;

  assign unused_bits = ^{bus.paddr[1:0], bus.pwdata};

endmodule

// File: tb/tb_fifo_apb_dac.sv
// Scenario bench for fifo_apb_dac: expected DAC words are queued as they are
// written and matched against words the DAC side accepts.
module tb_fifo_apb_dac;
  import fifo_apb_dac_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_apb_dac_if #(.DATA_WIDTH(16)) bus ();

  fifo_apb_dac #(
    .DATA_WIDTH   (16),
    .DEPTH        (16),
    .PERIOD_WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;

  logic [15:0] exp_q [$];
  logic [15:0] got_d [$];
  int unsigned got_c [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted DAC word with the cycle it was presented in
  always @(negedge clk) begin
    if (rst_n && bus.dac_valid && bus.dac_ready) begin
      got_d.push_back(bus.dac_data);
      got_c.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = a; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    d = bus.prdata;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_d.size() >= n) break;
      tick(1);
    end
    if (got_d.size() >= n) ok = 1'b1;
  endtask

  task automatic flush_sb();
    exp_q.delete(); got_d.delete(); got_c.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #2;
    checks++; if (bus.dac_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.dac_valid); end
    checks++; if (bus.dac_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.dac_data); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    checks++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b0) begin errors++; $display("FAIL reset_resp: got pready=%b pslverr=%b want 1/0", bus.pready, bus.pslverr); end
    @(posedge clk); #1; rst_n = 1'b1;
    tick(1);
    apb_read(OFF_STATUS, r);
    checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h want 00000001", r); end
    apb_read(OFF_CTRL, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 00000000", r); end
    apb_read(OFF_PERIOD, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_period: got %h want 00000000", r); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic [31:0] r;
    logic [15:0] e, g;
    bit ok;
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    apb_write(OFF_PERIOD, 32'h0);
    bus.dac_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apb_write(OFF_DATA, {16'h0, vals[i]});
      exp_q.push_back(vals[i]);
    end
    apb_write(OFF_CTRL, 32'h1);
    wait_got(3, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d words want 3", got_d.size()); end
    if (ok) begin
      checks++; if (got_c[1] != got_c[0] + 1 || got_c[2] != got_c[1] + 1) begin
        errors++; $display("FAIL b2b_spacing: got cycles %0d,%0d,%0d want consecutive", got_c[0], got_c[1], got_c[2]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_d.size() == 0) begin errors++; $display("FAIL b2b_data: got nothing want %h", e); end
      else begin
        g = got_d.pop_front(); void'(got_c.pop_front());
        if (g !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", g, e); end
      end
    end
    apb_read(OFF_STATUS, r);
    checks++; if (r[15:8] !== 8'd0 || r[ST_EMPTY] !== 1'b1) begin errors++; $display("FAIL b2b_drained: got status %h want count 0 empty 1", r); end
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_STATUS, 32'h0003_0000);
    flush_sb();
  endtask

  task automatic test_pacing();
    logic [31:0] r;
    logic [15:0] e, g;
    bit ok;
    apb_write(OFF_PERIOD, 32'd4);
    bus.dac_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apb_write(OFF_DATA, 32'h0000_a000 + i);
      exp_q.push_back(16'ha000 + 16'(i));
    end
    apb_read(OFF_STATUS, r);
    checks++; if (r[15:8] !== 8'd3) begin errors++; $display("FAIL pace_count3: got %0d want 3", r[15:8]); end
    apb_write(OFF_CTRL, 32'h1);
    wait_got(3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pace_timeout: got %0d words want 3", got_d.size()); end
    if (ok) begin
      checks++; if (got_c[1] - got_c[0] != 5 || got_c[2] - got_c[1] != 5) begin
        errors++; $display("FAIL pace_spacing: got gaps %0d,%0d want 5,5", got_c[1] - got_c[0], got_c[2] - got_c[1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_d.size() == 0) begin errors++; $display("FAIL pace_data: got nothing want %h", e); end
      else begin
        g = got_d.pop_front(); void'(got_c.pop_front());
        if (g !== e) begin errors++; $display("FAIL pace_data: got %h want %h", g, e); end
      end
    end
    apb_read(OFF_STATUS, r);
    checks++; if (r[15:8] !== 8'd0) begin errors++; $display("FAIL pace_count0: got %0d want 0", r[15:8]); end
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_PERIOD, 32'h0);
    apb_write(OFF_STATUS, 32'h0003_0000);
    tick(6);
    flush_sb();
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [15:0] e, g;
    bit ok;
    bus.dac_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      apb_write(OFF_DATA, 32'h0000_0100 + i);
      if (i < 16) exp_q.push_back(16'h0100 + 16'(i));
    end
    apb_read(OFF_STATUS, r);
    checks++; if (r[ST_FULL] !== 1'b1 || r[ST_EMPTY] !== 1'b0 || r[15:8] !== 8'd16) begin
      errors++; $display("FAIL ovf_level: got status %h want full=1 empty=0 count=16", r);
    end
    checks++; if (r[ST_OVF] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", r[ST_OVF]); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_masked: got %b want 0", bus.irq); end
    apb_write(OFF_CTRL, 32'h4);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_en: got %b want 1", bus.irq); end
    apb_write(OFF_STATUS, 32'h0001_0000);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_w1c: got %b want 0", bus.irq); end
    apb_read(OFF_STATUS, r);
    checks++; if (r[ST_OVF] !== 1'b0 || r[ST_FULL] !== 1'b1) begin errors++; $display("FAIL ovf_w1c: got status %h want ovf=0 full=1", r); end
    apb_write(OFF_CTRL, 32'h1);
    bus.dac_ready = 1'b1;
    wait_got(16, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain_timeout: got %0d words want 16", got_d.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_d.size() == 0) begin errors++; $display("FAIL ovf_data: got nothing want %h", e); end
      else begin
        g = got_d.pop_front(); void'(got_c.pop_front());
        if (g !== e) begin errors++; $display("FAIL ovf_data: got %h want %h", g, e); end
      end
    end
    tick(3);
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL ovf_dropped: got %0d extra words want 0", got_d.size()); end
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_STATUS, 32'h0003_0000);
    flush_sb();
  endtask

  task automatic test_underrun();
    logic [31:0] r;
    logic [15:0] g;
    int unsigned c0;
    bit ok;
    apb_write(OFF_PERIOD, 32'd2);
    bus.dac_ready = 1'b1;
    apb_write(OFF_DATA, 32'h0000_0abc);
    exp_q.push_back(16'h0abc);
    apb_write(OFF_CTRL, 32'h5);
    wait_got(1, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL udr_timeout: got %0d words want 1", got_d.size()); end
    if (ok) begin
      c0 = got_c[0];
      g = got_d[0];
      checks++; if (g !== exp_q[0]) begin errors++; $display("FAIL udr_data: got %h want %h", g, exp_q[0]); end
      for (int i = 0; i < 10 && cyc < c0 + 2; i++) tick(1);
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL udr_early: got irq %b want 0 two cycles after send", bus.irq); end
      tick(1);
      checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL udr_set: got irq %b want 1 three cycles after send", bus.irq); end
    end
    apb_read(OFF_STATUS, r);
    checks++; if (r[ST_UDR] !== 1'b1 || r[ST_OVF] !== 1'b0) begin errors++; $display("FAIL udr_status: got status %h want bit17=1 bit16=0", r); end
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_PERIOD, 32'h0);
    apb_write(OFF_STATUS, 32'h0003_0000);
    tick(4);
    flush_sb();
  endtask

  task automatic test_stall_clear();
    logic [31:0] r;
    int bad;
    apb_write(OFF_CTRL, 32'h1);
    bus.dac_ready = 1'b0;
    apb_write(OFF_DATA, 32'h0000_5a5a);
    checks++; if (bus.dac_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got valid %b want 0 right after write", bus.dac_valid); end
    tick(1);
    checks++; if (bus.dac_valid !== 1'b1 || bus.dac_data !== 16'h5a5a) begin
      errors++; $display("FAIL lat_valid: got valid=%b data=%h want 1/5a5a", bus.dac_valid, bus.dac_data);
    end
    apb_write(OFF_DATA, 32'h0000_6b6b);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.dac_valid !== 1'b1 || bus.dac_data !== 16'h5a5a) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    apb_write(OFF_CTRL, 32'h3);
    checks++; if (bus.dac_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", bus.dac_valid); end
    apb_read(OFF_STATUS, r);
    checks++; if (r[ST_EMPTY] !== 1'b1 || r[15:8] !== 8'd0) begin errors++; $display("FAIL clear_empty: got status %h want empty count 0", r); end
    apb_read(OFF_CTRL, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL clear_ctrl: got %h want 00000001", r); end
    bus.dac_ready = 1'b1;
    tick(5);
    checks++; if (got_d.size() != 0 || bus.dac_valid !== 1'b0) begin
      errors++; $display("FAIL clear_discard: got %0d words valid=%b want 0/0", got_d.size(), bus.dac_valid);
    end
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_STATUS, 32'h0003_0000);
    flush_sb();
  endtask

  task automatic test_full_push_pop();
    logic [31:0] r;
    logic [15:0] e, g;
    bit ok;
    bus.dac_ready = 1'b0;
    apb_write(OFF_CTRL, 32'h1);
    for (int i = 0; i < 17; i++) begin
      apb_write(OFF_DATA, 32'h0000_0200 + i);
      exp_q.push_back(16'h0200 + 16'(i));
    end
    apb_read(OFF_STATUS, r);
    checks++; if (r[ST_FULL] !== 1'b1 || r[15:8] !== 8'd16 || r[ST_OVF] !== 1'b0) begin
      errors++; $display("FAIL fpp_prefill: got status %h want full=1 count=16 ovf=0", r);
    end
    // DATA write whose access edge coincides with the DAC taking the held word
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = OFF_DATA; bus.pwdata = 32'h0000_02ff; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1; bus.dac_ready = 1'b1;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.dac_ready = 1'b0;
    exp_q.push_back(16'h02ff);
    apb_read(OFF_STATUS, r);
    checks++; if (r[15:8] !== 8'd16 || r[ST_FULL] !== 1'b1) begin errors++; $display("FAIL fpp_count: got status %h want count=16 full=1", r); end
    checks++; if (r[ST_OVF] !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b want 0", r[ST_OVF]); end
    bus.dac_ready = 1'b1;
    wait_got(18, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fpp_timeout: got %0d words want 18", got_d.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_d.size() == 0) begin errors++; $display("FAIL fpp_data: got nothing want %h", e); end
      else begin
        g = got_d.pop_front(); void'(got_c.pop_front());
        if (g !== e) begin errors++; $display("FAIL fpp_data: got %h want %h", g, e); end
      end
    end
    apb_write(OFF_CTRL, 32'h0);
    apb_write(OFF_STATUS, 32'h0003_0000);
    flush_sb();
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    bus.dac_ready = 1'b0;
    apb_write(OFF_CTRL, 32'h5);
    apb_write(OFF_PERIOD, 32'h7);
    apb_write(OFF_DATA, 32'h0000_7777);
    tick(1);
    checks++; if (bus.dac_valid !== 1'b1) begin errors++; $display("FAIL ar_pre: got valid %b want 1", bus.dac_valid); end
    #3; rst_n = 1'b0; #1;
    checks++; if (bus.dac_valid !== 1'b0 || bus.dac_data !== 16'h0) begin
      errors++; $display("FAIL ar_outputs: got valid=%b data=%h want 0/0000", bus.dac_valid, bus.dac_data);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    apb_read(OFF_STATUS, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL ar_status: got %h want 00000001", r); end
    apb_read(OFF_PERIOD, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ar_period: got %h want 00000000", r); end
    flush_sb();
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.dac_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_pacing();
    test_overflow();
    test_underrun();
    test_stall_clear();
    test_full_push_pop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
